vram_init_seq: RTL
==================

// Module: vram_init_seq
// PURPOSE
//  Descriptor-driven VRAM initialiser; replaces the hard-coded per-region CPU init stub.
//  Walks NUM_REGIONS descriptors {base, count, mode, arg}: sprite/BG params, map, tiles, palettes.
//  For each descriptor, writes one generated word per granted cycle to the VRAM bus.
//  Afterwards optionally issues a per-frame scroll write on vsync. Sits ahead of the CPU on the VRAM arbiter.
// PARAMETERS
//  NUM_REGIONS  8    descriptor slots, walked in index order 0..NUM_REGIONS-1
//  CNT_W        17   width of count/index (max region 2^CNT_W-1 words)
//  PAL_DEPTH    8    depth of colour LUT used by MODE_LUT
//  START_DELAY  100  idle cycles between start and first write
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          synchronous active-low reset
//  start      in   1          pulse; accepted only in IDLE or DONE
//  cfg_we     in   1          config write strobe; ignored unless IDLE or DONE
//  cfg_sel    in   1          0=descriptor field, 1=LUT entry
//  cfg_idx    in   8          descriptor index or LUT index
//  cfg_fld    in   2          0=base 1=count 2=mode 3=arg (cfg_sel=0 only)
//  cfg_wdata  in   32         config data
//  vsync      in   1          frame sync, level; used only with VSYNC_SCROLL_EN
//  busy       out  1          high from start accept until DONE
//  done       out  1          high in DONE until next start or reset
//  mem_en     out  1          write request
//  mem_we     out  1          = mem_en (block only writes)
//  mem_addr   out  32         word address
//  mem_din    out  32         write data
//  mem_gnt    in   1          arbiter grant; a beat completes when mem_en && mem_gnt
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
//    Descriptors cleared to count=0; LUT cleared to 0; scroll x/y=0.
//  Reset mid-run: abandons the run immediately. No further mem_en.
//  FSM states and transitions:
//    IDLE -start-> DELAY (START_DELAY cycles) -> LOAD.
//    LOAD: latch descriptor r; i=0, j=0. If count==0, go to NEXT (skip).
//    LOAD -> RUN.
//    RUN: drive request; on a granted beat, i++ and j++ (j wraps to 0 at arg-1).
//      Last beat (i==count-1 granted) -> NEXT.
//    NEXT: r++. If r==NUM_REGIONS -> DONE, else -> LOAD.
//    DONE: busy=0, done=1; start -> DELAY again (full re-run).
//  Handshake:
//    mem_en/addr/din are registered and held stable while !mem_gnt; stalls are unbounded.
//    Throughput is 1 beat/cycle under continuous grant.
//    LOAD and NEXT each cost one bubble cycle.
//  Address: mem_addr = base + i, 32-bit, wraps modulo 2^32.
//  Data by mode (mode[2:0]):
//    0 CONST: arg
//    1 INC:   i (zero-extended)
//    2 DIV:   i >> arg[4:0]
//    3 WRAP:  j
//    4 LUT:   lut[j % PAL_DEPTH], with j wrapping at arg
//    5-7:     treated as CONST
//  WRAP/LUT with arg==0: treated as arg=1, so j stays 0.
//  start while busy: ignored. Simultaneous start and reset: reset wins.
// CONFIGURATION
//  `VSYNC_SCROLL_EN defined: extra ports scroll_addr in 32, scroll_en in 1.
//    In DONE, a rising edge of vsync (registered prev) issues one write:
//      addr = scroll_addr, data = {1'b1, 15'b0, x[7:0], y[7:0]}.
//    x and y increment by 1 after each granted scroll beat, wrapping at 8 bits.
//    Gated by scroll_en. A pending scroll write is held until granted.
//    A new vsync edge during a pending write is dropped.
//  Not defined: no scroll logic; in DONE, mem_en stays 0.
// STRUCTURE
//  gameconsole_pkg gets:
//    typedef vinit_mode_e {CONST, INC, DIV, WRAP, LUT}
//    struct vinit_desc_t {base, count, mode, arg}
//    VRAM base-address constants.
//  Sub-module vinit_datagen: combinational data generator from (mode, arg, i, j, lut). Keeps the FSM lean.
// TESTING
//  T1: desc0 {base=0x0600_0000, count=4, CONST, arg=0x8000_0000}; mem_gnt=1; start
//      -> after 100 idle cycles, 4 consecutive beats at 0x0600_0000..0003, data 0x8000_0000; then done=1.
//  T2: desc0 count=0, desc1 {0x0610_0000, 3, INC}
//      -> desc0 skipped; beats 0x0610_0000..2 with data 0,1,2.
//  T3: LUT loaded 0..6 = colours; desc {0x0630_0000, 9, LUT, arg=7}
//      -> data sequence lut[0..6], lut[0], lut[1].
//  T4: mem_gnt toggled 1-0-0-1 during DIV arg=6, count=130
//      -> addr/din held stable during stall; beats 63/64 carry data 0/1; no lost or duplicated beats.
//  T5: rst_n low at beat 5 of 10 -> next cycle mem_en=0, busy=0.
//      Restart -> full sequence from desc0.
//  T6 (VSYNC_SCROLL_EN): in DONE, 3 vsync pulses, scroll_en=1
//      -> 3 writes to scroll_addr with data 0x8000_0000, 0x8000_0101, 0x8000_0202.

Source files
------------

// File: rtl/vram_init_seq_pkg.sv
// Shared types and constants for the descriptor-driven VRAM initialiser.
// Count width is fixed here because the descriptor struct is packed.
package vram_init_seq_pkg;

    localparam int unsigned VINIT_CNT_W       = 17;
    localparam int unsigned VINIT_NUM_REGIONS = 8;
    localparam int unsigned VINIT_PAL_DEPTH   = 8;
    localparam int unsigned VINIT_START_DELAY = 100;

    localparam logic [31:0] VRAM_SPR_BASE = 32'h0600_0000;
    localparam logic [31:0] VRAM_BG_BASE  = 32'h0610_0000;
    localparam logic [31:0] VRAM_MAP_BASE = 32'h0620_0000;
    localparam logic [31:0] VRAM_PAL_BASE = 32'h0630_0000;

    typedef enum logic [2:0] {
        ModeConst = 3'd0,
        ModeInc   = 3'd1,
        ModeDiv   = 3'd2,
        ModeWrap  = 3'd3,
        ModeLut   = 3'd4
    } vinit_mode_e;

    // Mode is kept raw so that the undefined encodings 5-7 can be stored and decoded as CONST.
    typedef struct packed {
        logic [31:0]            base;
        logic [VINIT_CNT_W-1:0] count;
        logic [2:0]             mode;
        logic [31:0]            arg;
    } vinit_desc_t;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StLoad,
        StRun,
        StNext,
        StDone
    } vinit_state_e;

    // A wrap period of zero behaves like one, pinning j at zero.
    function automatic logic [31:0] vinit_wrap_len(input logic [31:0] arg);
        return (arg == 32'd0) ? 32'd1 : arg;
    endfunction

endpackage

// File: rtl/vram_init_seq_datagen.sv
// Combinational write-data generator for one descriptor beat.
module vram_init_seq_datagen
    import vram_init_seq_pkg::*;
#(
    parameter int unsigned PAL_DEPTH = VINIT_PAL_DEPTH
) (
    input  logic [2:0]                  mode,
    input  logic [31:0]                 arg,
    input  logic [VINIT_CNT_W-1:0]      i,
    input  logic [VINIT_CNT_W-1:0]      j,
    input  logic [PAL_DEPTH-1:0][31:0]  lut,
    output logic [31:0]                 data
);

    localparam int unsigned LUT_W = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;

    logic [VINIT_CNT_W-1:0] lut_sel;
    logic [31:0]            i_ext;

    always_comb begin
        i_ext   = 32'(i);
        lut_sel = j % VINIT_CNT_W'(PAL_DEPTH);
        data    = arg;
        case (vinit_mode_e'(mode))
            ModeConst: data = arg;
            ModeInc:   data = i_ext;
            ModeDiv:   data = i_ext >> arg[4:0];
            ModeWrap:  data = 32'(j);
            ModeLut:   data = lut[lut_sel[LUT_W-1:0]];
            default:   data = arg;
        endcase
    end

endmodule

// File: rtl/vram_init_seq.sv
// Descriptor-driven VRAM initialiser: walks region descriptors and streams generated words.
// Optional per-frame scroll write in DONE when VSYNC_SCROLL_EN is defined.
module vram_init_seq
    import vram_init_seq_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = VINIT_NUM_REGIONS,
    parameter int unsigned PAL_DEPTH   = VINIT_PAL_DEPTH,
    parameter int unsigned START_DELAY = VINIT_START_DELAY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [7:0]  cfg_idx,
    input  logic [1:0]  cfg_fld,
    input  logic [31:0] cfg_wdata,
    input  logic        vsync,
`ifdef VSYNC_SCROLL_EN
    input  logic [31:0] scroll_addr,
    input  logic        scroll_en,
`endif
    output logic        busy,
    output logic        done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic        mem_gnt
);

    localparam int unsigned RIDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned LUT_W    = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
    localparam int unsigned DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int unsigned DLY_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

    vinit_state_e           state_q, state_d;
    logic [RIDX_W-1:0]      r_q, r_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic [VINIT_CNT_W-1:0] i_q, i_nxt;
    logic [VINIT_CNT_W-1:0] j_q, j_nxt;
    vinit_desc_t            cur_q, cur_d;
    logic                   mem_en_q, mem_en_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [31:0]            mem_din_q, mem_din_d;

    vinit_desc_t              desc_q [NUM_REGIONS];
    logic [PAL_DEPTH-1:0][31:0] lut_q;

    vinit_desc_t gen_desc;
    logic [31:0] gen_data;
    logic        beat;
    logic        last_beat;
    logic        j_wrap;
    logic        cfg_open;

`ifdef VSYNC_SCROLL_EN
    logic       vsync_q;
    logic [7:0] scroll_x_q, scroll_x_d;
    logic [7:0] scroll_y_q, scroll_y_d;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    assign cfg_open = (state_q == StIdle) || (state_q == StDone);

    // Descriptor and LUT storage; only writable while no run is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGIONS; k++) begin
                desc_q[k] <= '0;
            end
            lut_q <= '0;
        end else if (cfg_we && cfg_open) begin
            if (!cfg_sel) begin
                if (32'(cfg_idx) < NUM_REGIONS) begin
                    case (cfg_fld)
                        2'd0: desc_q[cfg_idx[RIDX_W-1:0]].base  <= cfg_wdata;
                        2'd1: desc_q[cfg_idx[RIDX_W-1:0]].count <= cfg_wdata[VINIT_CNT_W-1:0];
                        2'd2: desc_q[cfg_idx[RIDX_W-1:0]].mode  <= cfg_wdata[2:0];
                        default: desc_q[cfg_idx[RIDX_W-1:0]].arg <= cfg_wdata;
                    endcase
                end
            end else if (32'(cfg_idx) < PAL_DEPTH) begin
                lut_q[cfg_idx[LUT_W-1:0]] <= cfg_wdata;
            end
        end
    end

    // Beat indices for the word being prepared; kept apart from the FSM to avoid a false loop.
    always_comb begin
        gen_desc  = (state_q == StLoad) ? desc_q[r_q] : cur_q;
        beat      = mem_en_q && mem_gnt;
        last_beat = (i_q == cur_q.count - VINIT_CNT_W'(1));
        j_wrap    = (32'(j_q) + 32'd1) >= vinit_wrap_len(cur_q.arg);
        i_nxt     = i_q;
        j_nxt     = j_q;
        if (state_q == StLoad) begin
            i_nxt = '0;
            j_nxt = '0;
        end else if ((state_q == StRun) && beat) begin
            i_nxt = i_q + VINIT_CNT_W'(1);
            j_nxt = j_wrap ? '0 : j_q + VINIT_CNT_W'(1);
        end
    end

    vram_init_seq_datagen #(
        .PAL_DEPTH (PAL_DEPTH)
    ) u_datagen (
        .mode (gen_desc.mode),
        .arg  (gen_desc.arg),
        .i    (i_nxt),
        .j    (j_nxt),
        .lut  (lut_q),
        .data (gen_data)
    );

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        dly_d      = dly_q;
        cur_d      = cur_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
`ifdef VSYNC_SCROLL_EN
        scroll_x_d = scroll_x_q;
        scroll_y_d = scroll_y_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDelay;
                    dly_d   = '0;
                    r_d     = '0;
                end
            end
            StDelay: begin
                if (32'(dly_q) >= DLY_LAST) begin
                    state_d = StLoad;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            StLoad: begin
                cur_d = desc_q[r_q];
                if (desc_q[r_q].count == '0) begin
                    state_d = StNext;
                end else begin
                    state_d    = StRun;
                    mem_en_d   = 1'b1;
                    mem_addr_d = desc_q[r_q].base;
                    mem_din_d  = gen_data;
                end
            end
            StRun: begin
                if (beat) begin
                    if (last_beat) begin
                        mem_en_d = 1'b0;
                        state_d  = StNext;
                    end else begin
                        mem_addr_d = cur_q.base + 32'(i_nxt);
                        mem_din_d  = gen_data;
                    end
                end
            end
            StNext: begin
                if (32'(r_q) >= NUM_REGIONS - 1) begin
                    state_d = StDone;
                end else begin
                    r_d     = r_q + RIDX_W'(1);
                    state_d = StLoad;
                end
            end
            StDone: begin
`ifdef VSYNC_SCROLL_EN
                // A pending scroll beat must finish first, so start waits behind it.
                if (mem_en_q) begin
                    if (mem_gnt) begin
                        mem_en_d   = 1'b0;
                        scroll_x_d = scroll_x_q + 8'd1;
                        scroll_y_d = scroll_y_q + 8'd1;
                    end
                end else if (start) begin
                    state_d = StDelay;
                    dly_d   = '0;
                    r_d     = '0;
                end else if (scroll_en && vsync && !vsync_q) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = scroll_addr;
                    mem_din_d  = {1'b1, 15'b0, scroll_x_q, scroll_y_q};
                end
`else
                if (start) begin
                    state_d = StDelay;
                    dly_d   = '0;
                    r_d     = '0;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            r_q        <= '0;
            dly_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            cur_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            dly_q      <= dly_d;
            i_q        <= i_nxt;
            j_q        <= j_nxt;
            cur_q      <= cur_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

`ifdef VSYNC_SCROLL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            scroll_x_q <= '0;
            scroll_y_q <= '0;
        end else begin
            vsync_q    <= vsync;
            scroll_x_q <= scroll_x_d;
            scroll_y_q <= scroll_y_d;
        end
    end
`endif

    assign busy     = (state_q == StDelay) || (state_q == StLoad) ||
                      (state_q == StRun)   || (state_q == StNext);
    assign done     = (state_q == StDone);
    assign mem_en   = mem_en_q;
    assign mem_we   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
